// File: rtl/desc_pixel_packer_if.sv
// Pixel-in / packed-word-out handshake bundle for desc_pixel_packer.
// The master modport is the stream source and word consumer; the slave modport is the packer.
interface desc_pixel_packer_if;
   logic [7:0]  pixel_in;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [31:0] desc_data_out;
   logic        desc_data_ready;

   modport master (
      output pixel_in, pixel_valid,
      input  pixel_ready, desc_data_out, desc_data_ready
   );

   modport slave (
      input  pixel_in, pixel_valid,
      output pixel_ready, desc_data_out, desc_data_ready
   );
endinterface

// File: rtl/desc_pixel_packer.sv
// Packs a byte pixel stream into 32-bit descriptor words and strobes each word once.
// Optional macro DESC_PACK_ZERO_CLAMP_EN: stores received 8'h00 pixels as 8'h01.
module desc_pixel_packer #(
   parameter int NUM_WORDS  = 64,
   parameter int GAP_CYCLES = 1,
   localparam int WCW = $clog2(NUM_WORDS + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   desc_pixel_packer_if.slave   bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [WCW-1:0]       o_word_count
);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PACK, S_ISSUE, S_GAP, S_DONE} state_t;

   state_t        r_state;
   logic [1:0]    r_idx;
   logic [31:0]   r_pack;
   logic [31:0]   r_data;
   logic          r_strobe;
   logic          r_pixel_ready;
   logic          r_busy;
   logic          r_done;
   logic [WCW-1:0] r_wcnt;
   logic [GW-1:0] r_gap;

   logic          w_accept;
   logic [7:0]    w_pix;
   logic [31:0]   w_pack_nxt;

   // r_pixel_ready is only ever high in PACK, so it doubles as the state qualifier
   assign w_accept = bus.pixel_valid & r_pixel_ready;

   always_comb begin
      w_pix = bus.pixel_in;
`ifdef DESC_PACK_ZERO_CLAMP_EN
      if (bus.pixel_in == 8'h00) w_pix = 8'h01;
`endif
      w_pack_nxt = r_pack;
      case (r_idx)
         2'd0:    w_pack_nxt[31:24] = w_pix;
         2'd1:    w_pack_nxt[23:16] = w_pix;
         2'd2:    w_pack_nxt[15:8]  = w_pix;
         default: w_pack_nxt[7:0]   = w_pix;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_idx         <= 2'd0;
         r_pack        <= 32'd0;
         r_data        <= 32'd0;
         r_strobe      <= 1'b0;
         r_pixel_ready <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_wcnt        <= '0;
         r_gap         <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state       <= S_PACK;
                  r_idx         <= 2'd0;
                  r_pack        <= 32'd0;
                  r_wcnt        <= '0;
                  r_pixel_ready <= 1'b1;
                  r_busy        <= 1'b1;
                  r_done        <= 1'b0;
               end
            end
            S_PACK: begin
               if (w_accept) begin
                  r_pack <= w_pack_nxt;
                  r_idx  <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_state       <= S_ISSUE;
                     r_data        <= w_pack_nxt;
                     r_strobe      <= 1'b1;
                     r_pixel_ready <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               r_state  <= S_GAP;
               r_strobe <= 1'b0;
               r_wcnt   <= r_wcnt + WCW'(1);
               r_gap    <= '0;
            end
            S_GAP: begin
               if (r_gap == GW'(GAP_CYCLES - 1)) begin
                  if (r_wcnt == WCW'(NUM_WORDS)) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= S_PACK;
                     r_pixel_ready <= 1'b1;
                  end
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.pixel_ready     = r_pixel_ready;
   assign bus.desc_data_out   = r_data;
   assign bus.desc_data_ready = r_strobe;
   assign o_busy              = r_busy;
   assign o_done              = r_done;
   assign o_word_count        = r_wcnt;
endmodule
